// File: rtl/sdram_row_sequencer_if.sv
// Line-request and SDRAM row-command signals between the video line buffers,
// the row sequencer and the SDRAM controller.
interface sdram_row_sequencer_if;
    logic        FRAME_START_WR;
    logic        LINE_WR_REQ;
    logic        FRAME_START_RD;
    logic        LINE_RD_REQ;
    logic        END_OPERATION;
    logic        C_WRITE;
    logic        C_READ;
    logic [1:0]  C_BANK;
    logic [12:0] C_ROW_ADDRESS;
    logic        C_TYPE;
    logic        LINE_WR_ACK;
    logic        LINE_RD_ACK;
    logic        WR_OVERFLOW;
    logic        RD_UNDERRUN;
    logic        TIMEOUT_ERR;
    logic        BUSY;

    modport master (
        input  FRAME_START_WR, LINE_WR_REQ, FRAME_START_RD, LINE_RD_REQ, END_OPERATION,
        output C_WRITE, C_READ, C_BANK, C_ROW_ADDRESS, C_TYPE,
        output LINE_WR_ACK, LINE_RD_ACK, WR_OVERFLOW, RD_UNDERRUN, TIMEOUT_ERR, BUSY
    );

    modport slave (
        output FRAME_START_WR, LINE_WR_REQ, FRAME_START_RD, LINE_RD_REQ, END_OPERATION,
        input  C_WRITE, C_READ, C_BANK, C_ROW_ADDRESS, C_TYPE,
        input  LINE_WR_ACK, LINE_RD_ACK, WR_OVERFLOW, RD_UNDERRUN, TIMEOUT_ERR, BUSY
    );
endinterface

// File: rtl/sdram_row_sequencer.sv
// Sequences camera-line writes and display-line reads into SDRAM row commands
// over a triple-buffered set of banks (0..2), one line = two consecutive rows.
module sdram_row_sequencer #(
    parameter int LINES   = 288,
    parameter int TIMEOUT = 4095
) (
    input  logic                  clock_100,
    input  logic                  RESET_N,
    sdram_row_sequencer_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_END, S_DONE} state_t;

    localparam int          TW      = $clog2(TIMEOUT + 1);
    localparam logic [11:0] C_LINES = 12'(LINES);

    state_t        r_state, w_state_next;
    logic [11:0]   r_wr_line, r_rd_line;
    logic          r_wr_pend, r_rd_pend;
    logic          r_wr_restart, r_rd_restart;
    logic          r_op_wr;
    logic [1:0]    r_wr_bank, r_rdy_bank, r_rd_bank, r_bank;
    logic [12:0]   r_row;
    logic [TW-1:0] r_timer;
    logic          r_wr_ovf, r_rd_unr, r_to_err;

    logic       w_timeout, w_start_wr, w_start_rd;
    logic       w_done_wr, w_done_rd, w_end_wr, w_end_rd;
    logic       w_flight_wr, w_flight_rd, w_adv_wr, w_adv_rd, w_wrap;
    logic [1:0] w_rd_bank_eff;

    function automatic logic [1:0] f_free_bank(input logic [1:0] a, input logic [1:0] b);
        if (a != 2'd0 && b != 2'd0)
            return 2'd0;
        else if (a != 2'd1 && b != 2'd1)
            return 2'd1;
        else
            return 2'd2;
    endfunction

    always_comb begin
        w_timeout   = (r_state == S_WAIT_END) && !bus.END_OPERATION &&
                      (r_timer >= TW'(TIMEOUT - 1));
        w_start_wr  = (r_state == S_IDLE) && r_wr_pend;
        w_start_rd  = (r_state == S_IDLE) && !r_wr_pend && r_rd_pend;
        w_done_wr   = (r_state == S_DONE) && r_op_wr;
        w_done_rd   = (r_state == S_DONE) && !r_op_wr;
        w_end_wr    = w_done_wr || (w_timeout && r_op_wr);
        w_end_rd    = w_done_rd || (w_timeout && !r_op_wr);
        // A frame start counts as "in flight" from the cycle the op is chosen.
        w_flight_wr = ((r_state != S_IDLE) && r_op_wr) || w_start_wr;
        w_flight_rd = ((r_state != S_IDLE) && !r_op_wr) || w_start_rd;
        w_adv_wr    = w_done_wr && !r_wr_restart && !bus.FRAME_START_WR;
        w_adv_rd    = w_done_rd && !r_rd_restart && !bus.FRAME_START_RD;
        w_wrap      = w_adv_wr && (r_wr_line == C_LINES - 12'd1);
        w_rd_bank_eff = bus.FRAME_START_RD ? r_rdy_bank : r_rd_bank;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:     if (r_wr_pend || r_rd_pend) w_state_next = S_ISSUE;
            S_ISSUE:    w_state_next = S_WAIT_END;
            S_WAIT_END: begin
                if (bus.END_OPERATION)
                    w_state_next = S_DONE;
                else if (w_timeout)
                    w_state_next = S_IDLE;
            end
            S_DONE:     w_state_next = S_IDLE;
            default:    w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_100 or negedge RESET_N) begin
        if (!RESET_N)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_ff @(posedge clock_100 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_wr_line    <= '0;
            r_rd_line    <= '0;
            r_wr_pend    <= 1'b0;
            r_rd_pend    <= 1'b0;
            r_wr_restart <= 1'b0;
            r_rd_restart <= 1'b0;
            r_op_wr      <= 1'b0;
            r_wr_bank    <= 2'd0;
            r_rdy_bank   <= 2'd1;
            r_rd_bank    <= 2'd1;
            r_bank       <= 2'd0;
            r_row        <= '0;
            r_timer      <= '0;
            r_wr_ovf     <= 1'b0;
            r_rd_unr     <= 1'b0;
            r_to_err     <= 1'b0;
        end else begin
            if (bus.FRAME_START_WR) begin
                r_wr_line <= '0;
                r_wr_pend <= bus.LINE_WR_REQ;
            end else begin
                if (bus.LINE_WR_REQ) begin
                    if (r_wr_pend || r_wr_line == C_LINES)
                        r_wr_ovf <= 1'b1;
                    else
                        r_wr_pend <= 1'b1;
                end
                // After a restart the pending flag belongs to the new frame.
                if (w_end_wr && !r_wr_restart)
                    r_wr_pend <= 1'b0;
                if (w_adv_wr)
                    r_wr_line <= r_wr_line + 12'd1;
            end

            if (bus.FRAME_START_RD) begin
                r_rd_line <= '0;
                r_rd_pend <= bus.LINE_RD_REQ;
                r_rd_bank <= r_rdy_bank;
            end else begin
                if (bus.LINE_RD_REQ) begin
                    if (r_rd_pend || r_rd_line == C_LINES)
                        r_rd_unr <= 1'b1;
                    else
                        r_rd_pend <= 1'b1;
                end
                if (w_end_rd && !r_rd_restart)
                    r_rd_pend <= 1'b0;
                if (w_adv_rd)
                    r_rd_line <= r_rd_line + 12'd1;
            end

            if (w_end_wr)
                r_wr_restart <= 1'b0;
            else if (bus.FRAME_START_WR && w_flight_wr)
                r_wr_restart <= 1'b1;

            if (w_end_rd)
                r_rd_restart <= 1'b0;
            else if (bus.FRAME_START_RD && w_flight_rd)
                r_rd_restart <= 1'b1;

            // New write bank must avoid the finished frame and the bank being displayed.
            if (w_wrap) begin
                r_rdy_bank <= r_wr_bank;
                r_wr_bank  <= f_free_bank(r_wr_bank, w_rd_bank_eff);
            end

            if (w_start_wr || w_start_rd) begin
                r_op_wr <= r_wr_pend;
                r_bank  <= r_wr_pend ? r_wr_bank : r_rd_bank;
                r_row   <= r_wr_pend ? {r_wr_line, 1'b0} : {r_rd_line, 1'b0};
            end

            if (r_state == S_IDLE)
                r_timer <= '0;
            else
                r_timer <= r_timer + TW'(1);

            if (w_timeout)
                r_to_err <= 1'b1;
        end
    end

    assign bus.C_WRITE       = (r_state == S_ISSUE) && r_op_wr;
    assign bus.C_READ        = (r_state == S_ISSUE) && !r_op_wr;
    assign bus.C_BANK        = r_bank;
    assign bus.C_ROW_ADDRESS = r_row;
    assign bus.C_TYPE        = 1'b1;
    assign bus.LINE_WR_ACK   = w_done_wr;
    assign bus.LINE_RD_ACK   = w_done_rd;
    assign bus.WR_OVERFLOW   = r_wr_ovf;
    assign bus.RD_UNDERRUN   = r_rd_unr;
    assign bus.TIMEOUT_ERR   = r_to_err;
    assign bus.BUSY          = (r_state != S_IDLE);
endmodule

// File: doc/sdram_row_sequencer.md
SDRAM_ROW_SEQUENCER -- requirements
Module: sdram_row_sequencer

Interface
REQ-001 SHALL have parameter LINES, default 288: video lines per frame, 1..4095.
REQ-002 SHALL have parameter TIMEOUT, default 4095: maximum cycles to wait for END_OPERATION.
REQ-003 SHALL have port clock_100  in  1  sole clock, rising-edge.
REQ-004 SHALL have port RESET_N  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port FRAME_START_WR  in  1  one-cycle pulse, camera frame begins.
REQ-006 SHALL have port LINE_WR_REQ  in  1  one-cycle pulse, camera line buffered and ready to store.
REQ-007 SHALL have port FRAME_START_RD  in  1  one-cycle pulse, display frame begins.
REQ-008 SHALL have port LINE_RD_REQ  in  1  one-cycle pulse, display needs next line.
REQ-009 SHALL have port END_OPERATION  in  1  controller completion pulse.
REQ-010 SHALL have port C_WRITE  out  1  one-cycle write-row command to the SDRAM controller.
REQ-011 SHALL have port C_READ  out  1  one-cycle read-row command.
REQ-012 SHALL have port C_BANK  out  2  target bank.
REQ-013 SHALL have port C_ROW_ADDRESS  out  13  first SDRAM row of the line.
REQ-014 SHALL have port C_TYPE  out  1  constant 1: split-line mode, two SDRAM rows per line.
REQ-015 SHALL have ports LINE_WR_ACK, LINE_RD_ACK  out  1 each  one-cycle pulse, line transfer done.
REQ-016 SHALL have ports WR_OVERFLOW, RD_UNDERRUN, TIMEOUT_ERR  out  1 each  sticky error flags.
REQ-017 SHALL have port BUSY  out  1  high from command issue until completion or timeout.

Function
REQ-018 SHALL implement FSM IDLE -> ISSUE -> WAIT_END -> DONE -> IDLE.
REQ-019 IDLE: if write pending, go to ISSUE as write; else if read pending, go to ISSUE as read; write always has priority.
REQ-020 ISSUE: assert exactly one of C_WRITE/C_READ for one cycle; then go to WAIT_END.
REQ-021 C_BANK and C_ROW_ADDRESS SHALL be latched on entering ISSUE and held stable until DONE, because the controller derives the second half-row as C_ROW_ADDRESS+1 late in the operation.
REQ-022 WAIT_END: on END_OPERATION go to DONE; a cycle counter reaching TIMEOUT sets TIMEOUT_ERR and goes to IDLE without ACK, and the request is not retried.
REQ-023 DONE: pulse the matching ACK for one cycle, advance that direction's line counter by 1 and row address by 2, clear its pending flag, then go to IDLE.
REQ-024 Row address SHALL be 2*line_index, 13-bit; line_index is 12-bit, and LINES*2 SHALL be <= 8192.
REQ-025 Each pending flag SHALL be set by its *_REQ pulse; a *_REQ arriving while its flag is already set SHALL set WR_OVERFLOW (write) or RD_UNDERRUN (read) and be dropped.
REQ-026 A *_REQ when that direction's line_index == LINES SHALL be dropped and SHALL set the same error flag.
REQ-027 Triple buffering: write bank wr_bank, ready bank rdy_bank, read bank rd_bank, each in {0,1,2}; bank 3 is never used.
REQ-028 On the write that completes line LINES-1: rdy_bank <= wr_bank, and wr_bank <= the bank in {0,1,2} differing from both the old wr_bank and rd_bank.
REQ-029 FRAME_START_RD: rd_bank <= rdy_bank, read line_index <= 0, read pending cleared.
REQ-030 FRAME_START_WR: write line_index <= 0, write pending cleared.
REQ-031 FRAME_START_* in the same cycle as the matching *_REQ: the counter resets and the request is accepted for line 0.
REQ-032 FRAME_START_* while an operation of that direction is in flight: the in-flight operation completes with its latched address; DONE still pulses ACK but SHALL NOT advance the already-reset counter.
REQ-033 END_OPERATION outside WAIT_END SHALL be ignored.

Reset
REQ-034 While RESET_N is low, SHALL force: FSM IDLE; all outputs 0 except C_TYPE = 1; counters 0; pending flags 0; wr_bank = 0, rdy_bank = 1, rd_bank = 1.
REQ-035 Reset assertion mid-operation SHALL abort immediately, with no ACK pulse.

Verification
REQ-036 Reset, FRAME_START_WR, LINE_WR_REQ, END_OPERATION 50 cycles later -> one-cycle C_WRITE, C_BANK = 0, C_ROW_ADDRESS = 0 held stable throughout, LINE_WR_ACK pulse; next write uses row 2.
REQ-037 LINE_WR_REQ and LINE_RD_REQ in the same cycle -> write issued first, read issued after LINE_WR_ACK, both ACKed, no error flags.
REQ-038 LINES = 4 with rd_bank = 1: write 4 lines -> rdy_bank = 0, wr_bank = 2; then FRAME_START_RD -> reads target bank 0, rows 0, 2, 4, 6.
REQ-039 Second LINE_WR_REQ while the first is still pending -> WR_OVERFLOW = 1 and remains set; exactly one C_WRITE issued.
REQ-040 TIMEOUT = 16, no END_OPERATION -> TIMEOUT_ERR = 1 16 cycles after ISSUE, BUSY = 0, no ACK.
REQ-041 RESET_N low during WAIT_END -> all outputs at their reset values asynchronously, no ACK after release.
